// File: rtl/lc3_pipeline_controller.sv
// Central sequencer for the LC3 five-stage pipeline: stage enables, memory-access FSM,
// decode/execute hazard bypass selects and branch stall/resolution.
module lc3_pipeline_controller #(
  parameter int BR_STALL_CYCLES = 3,
  parameter int OPW             = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        complete_instr,
  input  logic        complete_data,
  input  logic [15:0] imem_dout,
  input  logic [15:0] ir,
  input  logic [15:0] ir_exec,
  input  logic [2:0]  psr,
  output logic        enable_updatepc,
  output logic        enable_fetch,
  output logic        enable_decode,
  output logic        enable_execute,
  output logic        enable_writeback,
  output logic        br_taken,
  output logic        bypass_alu_1,
  output logic        bypass_alu_2,
  output logic        bypass_mem_1,
  output logic        bypass_mem_2,
  output logic [1:0]  mem_state
);

  localparam logic [OPW-1:0] OP_BR  = 4'b0000;
  localparam logic [OPW-1:0] OP_ADD = 4'b0001;
  localparam logic [OPW-1:0] OP_LD  = 4'b0010;
  localparam logic [OPW-1:0] OP_ST  = 4'b0011;
  localparam logic [OPW-1:0] OP_AND = 4'b0101;
  localparam logic [OPW-1:0] OP_LDR = 4'b0110;
  localparam logic [OPW-1:0] OP_STR = 4'b0111;
  localparam logic [OPW-1:0] OP_NOT = 4'b1001;
  localparam logic [OPW-1:0] OP_LDI = 4'b1010;
  localparam logic [OPW-1:0] OP_STI = 4'b1011;
  localparam logic [OPW-1:0] OP_JMP = 4'b1100;
  localparam logic [OPW-1:0] OP_LEA = 4'b1110;

  localparam logic [1:0] BR_LOAD = 2'(BR_STALL_CYCLES);

  typedef enum logic [1:0] {
    MEM_READ     = 2'd0,
    MEM_INDIRECT = 2'd1,
    MEM_WRITE    = 2'd2,
    MEM_IDLE     = 2'd3
  } mem_state_t;

  mem_state_t mem_q;
  logic       indirect_store;
  logic       started;
  logic [1:0] br_count;

  logic [OPW-1:0] op_fetch, op_dec, op_exec;
  logic           mem_idle;
  logic           exec_alu, exec_load, exec_ctrl;
  logic           dec_uses_src1, dec_uses_src2;
  logic           src1_hit, src2_hit;
  logic           unused_bits;

  assign op_fetch = imem_dout[15:16-OPW];
  assign op_dec   = ir[15:16-OPW];
  assign op_exec  = ir_exec[15:16-OPW];

  assign unused_bits = ^{imem_dout[11:0], ir[11:9], ir[4:3], ir_exec[8:0]};

  assign mem_idle  = (mem_q == MEM_IDLE);
  assign exec_alu  = (op_exec == OP_ADD) || (op_exec == OP_AND) ||
                     (op_exec == OP_NOT) || (op_exec == OP_LEA);
  assign exec_load = (op_exec == OP_LD) || (op_exec == OP_LDR) || (op_exec == OP_LDI);
  assign exec_ctrl = (op_exec == OP_BR) || (op_exec == OP_JMP);

  assign dec_uses_src1 = (op_dec == OP_ADD) || (op_dec == OP_AND) || (op_dec == OP_NOT) ||
                         (op_dec == OP_LDR) || (op_dec == OP_STR) || (op_dec == OP_JMP);
  assign dec_uses_src2 = ((op_dec == OP_ADD) || (op_dec == OP_AND)) && !ir[5];

  assign src1_hit = dec_uses_src1 && (ir[8:6] == ir_exec[11:9]);
  assign src2_hit = dec_uses_src2 && (ir[2:0] == ir_exec[11:9]);

  // A memory stall freezes everything upstream of memory; a branch stall only freezes fetch.
  assign enable_execute   = started && mem_idle;
  assign enable_decode    = started && mem_idle;
  assign enable_fetch     = started && mem_idle && (br_count == 2'd0);
  assign enable_updatepc  = enable_fetch && complete_instr;
  assign enable_writeback = mem_idle ? started : ((mem_q == MEM_READ) && complete_data);
  assign mem_state        = mem_q;

  assign br_taken = mem_idle && (br_count == 2'd1) && exec_ctrl &&
                    ((op_exec == OP_JMP) || (|(ir_exec[11:9] & psr)));

  assign bypass_alu_1 = enable_execute && exec_alu  && src1_hit;
  assign bypass_alu_2 = enable_execute && exec_alu  && src2_hit;
  assign bypass_mem_1 = enable_execute && exec_load && src1_hit;
  assign bypass_mem_2 = enable_execute && exec_load && src2_hit;

  // Memory FSM, start-up flag and branch stall counter share one register block.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      mem_q          <= MEM_IDLE;
      indirect_store <= 1'b0;
      started        <= 1'b0;
      br_count       <= 2'd0;
    end else begin
      started <= 1'b1;
      case (mem_q)
        MEM_IDLE: begin
          if (enable_execute) begin
            case (op_exec)
              OP_LD, OP_LDR: mem_q <= MEM_READ;
              OP_ST, OP_STR: mem_q <= MEM_WRITE;
              OP_LDI: begin
                mem_q          <= MEM_INDIRECT;
                indirect_store <= 1'b0;
              end
              OP_STI: begin
                mem_q          <= MEM_INDIRECT;
                indirect_store <= 1'b1;
              end
              default: mem_q <= MEM_IDLE;
            endcase
          end
        end
        MEM_INDIRECT: begin
          if (complete_data) mem_q <= indirect_store ? MEM_WRITE : MEM_READ;
        end
        default: begin
          if (complete_data) mem_q <= MEM_IDLE;
        end
      endcase

      // The counter cannot load while non-zero, since fetch is already disabled then.
      if (enable_fetch && complete_instr && ((op_fetch == OP_BR) || (op_fetch == OP_JMP)))
        br_count <= BR_LOAD;
      else if ((br_count != 2'd0) && mem_idle)
        br_count <= br_count - 2'd1;
    end
  end

endmodule

// File: tb/tb_lc3_pipeline_controller.sv
// Directed self-checking bench for lc3_pipeline_controller.
// Inputs change just after each falling edge; outputs are checked 1 ns later.
module tb_lc3_pipeline_controller;

  logic        clock;
  logic        reset;
  logic        completeInstr;
  logic        completeData;
  logic [15:0] imemDout;
  logic [15:0] irDec;
  logic [15:0] irExec;
  logic [2:0]  psr;
  logic        enableUpdatepc, enableFetch, enableDecode, enableExecute, enableWriteback;
  logic        brTaken;
  logic        bypassAlu1, bypassAlu2, bypassMem1, bypassMem2;
  logic [1:0]  memState;

  int errors;
  int checks;

  lc3_pipeline_controller #(.BR_STALL_CYCLES(3)) dut (
    .clock            (clock),
    .reset            (reset),
    .complete_instr   (completeInstr),
    .complete_data    (completeData),
    .imem_dout        (imemDout),
    .ir               (irDec),
    .ir_exec          (irExec),
    .psr              (psr),
    .enable_updatepc  (enableUpdatepc),
    .enable_fetch     (enableFetch),
    .enable_decode    (enableDecode),
    .enable_execute   (enableExecute),
    .enable_writeback (enableWriteback),
    .br_taken         (brTaken),
    .bypass_alu_1     (bypassAlu1),
    .bypass_alu_2     (bypassAlu2),
    .bypass_mem_1     (bypassMem1),
    .bypass_mem_2     (bypassMem2),
    .mem_state        (memState)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic applyStimulus(input logic ci, input logic cd, input logic [15:0] imem,
                               input logic [15:0] irD, input logic [15:0] irE,
                               input logic [2:0] flags);
    @(negedge clock);
    completeInstr = ci;
    completeData  = cd;
    imemDout      = imem;
    irDec         = irD;
    irExec        = irE;
    psr           = flags;
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [15:0] observed,
                             input logic [15:0] expected);
    checks++;
    if (observed !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    reset = 1'b0;
    completeInstr = 1'b0;
    completeData = 1'b0;
    imemDout = 16'h0;
    irDec = 16'h0;
    irExec = 16'h0;
    psr = 3'b000;

    // Held in reset for three cycles with hazard-producing inputs present
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h1042, 16'h1201, 16'h1042, 3'b000);
      checkOutput("rst_fetch", enableFetch, 1'b0);
      checkOutput("rst_exec", enableExecute, 1'b0);
      checkOutput("rst_wb", enableWriteback, 1'b0);
      checkOutput("rst_byp1", bypassAlu1, 1'b0);
      checkOutput("rst_mem", memState, 2'd3);
    end
    @(negedge clock);
    reset = 1'b1;
    #1;
    checkOutput("rel_pre_upd", enableUpdatepc, 1'b0);

    // First edge after release enables every stage; ADD R1,R0,R1 after ADD R0
    applyStimulus(1'b1, 1'b0, 16'h1042, 16'h1201, 16'h1042, 3'b000);
    checkOutput("go_upd", enableUpdatepc, 1'b1);
    checkOutput("go_fetch", enableFetch, 1'b1);
    checkOutput("go_dec", enableDecode, 1'b1);
    checkOutput("go_exec", enableExecute, 1'b1);
    checkOutput("go_wb", enableWriteback, 1'b1);
    checkOutput("alu1_hit", bypassAlu1, 1'b1);
    checkOutput("alu2_miss", bypassAlu2, 1'b0);
    checkOutput("memb1_off", bypassMem1, 1'b0);

    applyStimulus(1'b1, 1'b0, 16'h1042, 16'h1240, 16'h1042, 3'b000);
    checkOutput("alu2_hit", bypassAlu2, 1'b1);
    checkOutput("alu1_miss", bypassAlu1, 1'b0);

    // STORE in execute never bypasses
    applyStimulus(1'b1, 1'b0, 16'h1042, 16'h1201, 16'h7042, 3'b000);
    checkOutput("st_nobyp", bypassAlu1, 1'b0);
    checkOutput("st_mem", memState, 2'd3);
    applyStimulus(1'b1, 1'b1, 16'h1042, 16'h1201, 16'h1042, 3'b000);
    checkOutput("st_wr", memState, 2'd2);
    checkOutput("st_wb", enableWriteback, 1'b0);

    // LD R0 in execute feeding src1 -> memory bypass, then one-cycle read
    applyStimulus(1'b1, 1'b0, 16'h1042, 16'h1201, 16'h2005, 3'b000);
    checkOutput("mem1_hit", bypassMem1, 1'b1);
    checkOutput("mem1_noalu", bypassAlu1, 1'b0);
    checkOutput("mem2_miss", bypassMem2, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h1042, 16'h1201, 16'h1042, 3'b000);
    checkOutput("ld_read", memState, 2'd0);
    checkOutput("ld_wb", enableWriteback, 1'b1);
    checkOutput("ld_exec", enableExecute, 1'b0);

    // Fetch hold while instruction memory is not ready
    applyStimulus(1'b0, 1'b0, 16'h1042, 16'h0000, 16'h1042, 3'b000);
    checkOutput("hold_upd", enableUpdatepc, 1'b0);
    checkOutput("hold_fetch", enableFetch, 1'b1);
    checkOutput("hold_dec", enableDecode, 1'b1);

    // LDI: mem_state 3,1,1,0,0,3 with complete_data on the 2nd and 4th stall cycles
    applyStimulus(1'b1, 1'b0, 16'h1042, 16'h0000, 16'hA005, 3'b000);
    checkOutput("ldi_c0", memState, 2'd3);
    applyStimulus(1'b1, 1'b0, 16'h1042, 16'h0000, 16'hA005, 3'b000);
    checkOutput("ldi_c1", memState, 2'd1);
    checkOutput("ldi_c1_fetch", enableFetch, 1'b0);
    checkOutput("ldi_c1_wb", enableWriteback, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h1042, 16'h0000, 16'hA005, 3'b000);
    checkOutput("ldi_c2", memState, 2'd1);
    checkOutput("ldi_c2_wb", enableWriteback, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h1042, 16'h0000, 16'hA005, 3'b000);
    checkOutput("ldi_c3", memState, 2'd0);
    checkOutput("ldi_c3_wb", enableWriteback, 1'b0);
    checkOutput("ldi_c3_exec", enableExecute, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'h1042, 16'h0000, 16'hA005, 3'b000);
    checkOutput("ldi_c4", memState, 2'd0);
    checkOutput("ldi_c4_wb", enableWriteback, 1'b1);
    checkOutput("ldi_c4_upd", enableUpdatepc, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'h1042, 16'h0000, 16'h1042, 3'b000);
    checkOutput("ldi_c5", memState, 2'd3);
    checkOutput("ldi_c5_exec", enableExecute, 1'b1);

    // BRz fetched with Z set: three-cycle stall, taken in the third
    applyStimulus(1'b1, 1'b0, 16'h0403, 16'h0000, 16'h1042, 3'b010);
    checkOutput("brz_ld_fetch", enableFetch, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h1042, 16'h0000, 16'h0403, 3'b010);
      checkOutput("brz_fetch", enableFetch, 1'b0);
      checkOutput("brz_upd", enableUpdatepc, 1'b0);
      checkOutput("brz_taken", brTaken, (i == 3) ? 1'b1 : 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 16'h1042, 16'h0000, 16'h0403, 3'b010);
    checkOutput("brz_after_fetch", enableFetch, 1'b1);
    checkOutput("brz_after_taken", brTaken, 1'b0);

    // Same branch with P set: not taken
    applyStimulus(1'b1, 1'b0, 16'h0403, 16'h0000, 16'h1042, 3'b001);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h1042, 16'h0000, 16'h0403, 3'b001);
      checkOutput("brp_fetch", enableFetch, 1'b0);
      checkOutput("brp_taken", brTaken, 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 16'h1042, 16'h0000, 16'h1042, 3'b001);
    checkOutput("brp_after_fetch", enableFetch, 1'b1);

    // STI in the memory FSM while a JMP sits on imem_dout
    applyStimulus(1'b1, 1'b0, 16'h1042, 16'h0000, 16'hB005, 3'b000);
    checkOutput("sti_c0", memState, 2'd3);
    applyStimulus(1'b1, 1'b1, 16'hC1C0, 16'h0000, 16'hB005, 3'b000);
    checkOutput("sti_c1", memState, 2'd1);
    checkOutput("sti_c1_fetch", enableFetch, 1'b0);
    applyStimulus(1'b1, 1'b1, 16'hC1C0, 16'h0000, 16'hB005, 3'b000);
    checkOutput("sti_c2", memState, 2'd2);
    checkOutput("sti_c2_wb", enableWriteback, 1'b0);
    applyStimulus(1'b1, 1'b0, 16'hC1C0, 16'h0000, 16'h1042, 3'b000);
    checkOutput("sti_c3", memState, 2'd3);
    checkOutput("sti_c3_fetch", enableFetch, 1'b1);
    for (int i = 1; i <= 3; i++) begin
      applyStimulus(1'b1, 1'b0, 16'h1042, 16'h0000, 16'hC1C0, 3'b000);
      checkOutput("jmp_fetch", enableFetch, 1'b0);
      checkOutput("jmp_taken", brTaken, (i == 3) ? 1'b1 : 1'b0);
    end
    applyStimulus(1'b1, 1'b0, 16'h1042, 16'h0000, 16'h1042, 3'b000);
    checkOutput("jmp_after_fetch", enableFetch, 1'b1);

    // Asynchronous reset while an indirect access is in flight
    applyStimulus(1'b1, 1'b0, 16'h1042, 16'h0000, 16'hA005, 3'b000);
    applyStimulus(1'b1, 1'b0, 16'h1042, 16'h0000, 16'h1042, 3'b000);
    checkOutput("mid_pre", memState, 2'd1);
    #1;
    reset = 1'b0;
    #1;
    checkOutput("mid_mem", memState, 2'd3);
    checkOutput("mid_exec", enableExecute, 1'b0);
    checkOutput("mid_wb", enableWriteback, 1'b0);
    checkOutput("mid_fetch", enableFetch, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
